store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/store_write_buffer_if.sv | 27 ++
 rtl/store_write_buffer.sv | 132 +++++++++++++
 tb/tb_store_write_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// Memory-side store bus between the write buffer and the memory port.
// The buffer is the master; memory answers with a non-zero acceptance tag.
interface store_write_buffer_if #(
  parameter int XLEN = 32
);
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [1:0]      proc2mem_size;
  logic [3:0]      mem2proc_response;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    output proc2mem_size,
    input  mem2proc_response
  );

  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    input  proc2mem_size,
    output mem2proc_response
  );
endinterface

// File: rtl/store_write_buffer.sv
// Retired-store FIFO: compacts up to N_WAY stores per cycle and drains
// them in order to memory, one per accepted response.
module store_write_buffer #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_WAY-1:0]            st_valid,
  input  logic [N_WAY-1:0][XLEN-1:0]  st_addr,
  input  logic [N_WAY-1:0][63:0]      st_data,
  input  logic [N_WAY-1:0][1:0]       st_size,
  input  logic [XLEN-1:0]             ld_check_addr,
  store_write_buffer_if.master        bus,
  output logic [$clog2(DEPTH):0]      free_slots,
  output logic                        empty,
  output logic                        ld_conflict,
  output logic                        overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_n;

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [63:0]     data_q [DEPTH];
  logic [1:0]      size_q [DEPTH];
  logic [DEPTH-1:0] vld;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_n, enq_n;

  logic [N_WAY-1:0]          lane_we;
  logic [N_WAY-1:0][PW-1:0]  lane_slot;
  logic                      ovf_set;
  logic                      pop;

  assign free_slots = CW'(DEPTH) - count;
  assign empty      = (count == '0);
  assign count_n    = count + enq_n - CW'(pop);

  // Capacity uses the registered count, so a same-cycle pop frees nothing yet.
  always_comb begin
    enq_n     = '0;
    ovf_set   = 1'b0;
    lane_we   = '0;
    lane_slot = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (st_valid[i]) begin
        if (enq_n < free_slots) begin
          lane_we[i]   = 1'b1;
          lane_slot[i] = tail + enq_n[PW-1:0];
          enq_n        = enq_n + CW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n               = state;
    pop                   = 1'b0;
    bus.proc2mem_command  = 2'd0;
    bus.proc2mem_addr     = '0;
    bus.proc2mem_data     = '0;
    bus.proc2mem_size     = '0;
    unique case (state)
      IDLE: begin
        if (count != '0) state_n = REQ;
      end
      REQ: begin
        bus.proc2mem_command = 2'd2;
        bus.proc2mem_addr    = addr_q[head];
        bus.proc2mem_data    = data_q[head];
        bus.proc2mem_size    = size_q[head];
        if (bus.mem2proc_response != 4'd0) begin
          pop = 1'b1;
          if ((count + enq_n) == CW'(1)) state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      vld      <= '0;
    end else begin
      count <= count_n;
      tail  <= tail + enq_n[PW-1:0];
      if (pop) begin
        head      <= head + PW'(1);
        vld[head] <= 1'b0;
      end
      for (int i = 0; i < N_WAY; i++) begin
        if (lane_we[i]) vld[lane_slot[i]] <= 1'b1;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (lane_we[i]) begin
        addr_q[lane_slot[i]] <= st_addr[i];
        data_q[lane_slot[i]] <= st_data[i];
        size_q[lane_slot[i]] <= st_size[i];
      end
    end
  end

  // Doubleword-granular match against held entries only.
  always_comb begin
    ld_conflict = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (vld[j] && (addr_q[j][XLEN-1:3] == ld_check_addr[XLEN-1:3]))
        ld_conflict = 1'b1;
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_store_write_buffer;
  localparam int N = 2;
  localparam int D = 8;
  localparam int X = 32;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0]         st_valid;
  logic [N-1:0][X-1:0]  st_addr;
  logic [N-1:0][63:0]   st_data;
  logic [N-1:0][1:0]    st_size;
  logic [X-1:0]         ld_check_addr;
  logic [3:0]           free_slots;
  logic                 empty, ld_conflict, overflow;

  store_write_buffer_if #(.XLEN(X)) bus();

  store_write_buffer #(.N_WAY(N), .DEPTH(D), .XLEN(X)) dut (
    .clock(clock),
    .reset(reset),
    .st_valid(st_valid),
    .st_addr(st_addr),
    .st_data(st_data),
    .st_size(st_size),
    .ld_check_addr(ld_check_addr),
    .bus(bus),
    .free_slots(free_slots),
    .empty(empty),
    .ld_conflict(ld_conflict),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
  } ent_t;

  ent_t mq[$];
  bit   m_req;
  bit   m_ovf;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
    logic [3:0]  r;
    logic [1:0]  ecmd;
    logic [31:0] eaddr;
    logic [63:0] edata;
    logic [1:0]  esize;
    int          efree;
    logic        eempty;
  } vec_t;

  vec_t tbl[13];
  logic [31:0] got[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a queue of pending stores; busy means a head is on the bus.
  task automatic model_edge();
    int fr;
    int took;
    int pre;
    bit was_req;
    if (reset) begin
      mq.delete();
      m_req = 0;
      m_ovf = 0;
      return;
    end
    fr = D - mq.size();
    pre = mq.size();
    took = 0;
    was_req = m_req;
    if (m_req && bus.mem2proc_response != 0) void'(mq.pop_front());
    for (int i = 0; i < N; i++) begin
      if (st_valid[i]) begin
        if (took < fr) begin
          mq.push_back('{a: st_addr[i], d: st_data[i], s: st_size[i]});
          took++;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_req = was_req ? (mq.size() > 0) : (pre > 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    st_valid = '0;
    st_addr = '0;
    st_data = '0;
    st_size = '0;
    ld_check_addr = '0;
    bus.mem2proc_response = 4'd0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_model();
    bit hit = 0;
    foreach (mq[k]) if (mq[k].a[31:3] == ld_check_addr[31:3]) hit = 1;
    chk("rnd_cmd", bus.proc2mem_command, m_req ? 2 : 0);
    chk("rnd_addr", bus.proc2mem_addr, m_req ? mq[0].a : 0);
    chk("rnd_data", bus.proc2mem_data, m_req ? mq[0].d : 0);
    chk("rnd_size", bus.proc2mem_size, m_req ? mq[0].s : 0);
    chk("rnd_free", free_slots, D - mq.size());
    chk("rnd_empty", empty, mq.size() == 0);
    chk("rnd_conflict", ld_conflict, hit);
    chk("rnd_overflow", overflow, m_ovf);
  endtask

  task automatic record_issue();
    if (bus.proc2mem_command == 2 && bus.mem2proc_response != 0)
      got.push_back(bus.proc2mem_addr);
  endtask

  initial begin
    int min_free;
    int n;
    int room;

    tbl[0]  = '{1, 32'h100, 64'hAB, 0, 1, 0, 0, 0, 0, 7, 0};
    tbl[1]  = '{0, 0, 0, 0, 1, 2, 32'h100, 64'hAB, 0, 7, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 8, 1};
    tbl[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 8, 1};
    tbl[4]  = '{1, 32'h40, 64'h11, 3, 0, 0, 0, 0, 0, 7, 0};
    tbl[5]  = '{1, 32'h48, 64'h22, 2, 0, 2, 32'h40, 64'h11, 3, 6, 0};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{0, 0, 0, 0, 0, 2, 32'h40, 64'h11, 3, 6, 0};
    tbl[11] = '{0, 0, 0, 0, 3, 2, 32'h48, 64'h22, 2, 7, 0};
    tbl[12] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 8, 1};

    clear_in();
    reset = 1'b1;
    m_req = 0;
    m_ovf = 0;
    tick();
    tick();
    reset = 1'b0;
    ld_check_addr = 32'h200;
    #1;
    chk("rst_cmd", bus.proc2mem_command, 0);
    chk("rst_addr", bus.proc2mem_addr, 0);
    chk("rst_data", bus.proc2mem_data, 0);
    chk("rst_size", bus.proc2mem_size, 0);
    chk("rst_free", free_slots, D);
    chk("rst_empty", empty, 1);
    chk("rst_conflict", ld_conflict, 0);
    chk("rst_overflow", overflow, 0);

    // single store and back-pressure table
    clear_in();
    for (int i = 0; i < 13; i++) begin
      st_valid[0] = tbl[i].v;
      st_addr[0] = tbl[i].a;
      st_data[0] = tbl[i].d;
      st_size[0] = tbl[i].s;
      bus.mem2proc_response = tbl[i].r;
      tick();
      chk($sformatf("tbl%0d_cmd", i), bus.proc2mem_command, tbl[i].ecmd);
      chk($sformatf("tbl%0d_addr", i), bus.proc2mem_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_data", i), bus.proc2mem_data, tbl[i].edata);
      chk($sformatf("tbl%0d_size", i), bus.proc2mem_size, tbl[i].esize);
      chk($sformatf("tbl%0d_free", i), free_slots, tbl[i].efree);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].eempty);
    end

    // wrap: 14 stores through an 8-deep buffer
    do_reset();
    got.delete();
    min_free = D;
    bus.mem2proc_response = 4'd1;
    for (int c = 0; c < 40; c++) begin
      st_valid = '0;
      if (c < 14) begin
        st_valid[0] = 1'b1;
        st_addr[0] = 32'(8 * c);
        st_data[0] = 64'(c);
      end
      if (free_slots < min_free) min_free = free_slots;
      record_issue();
      tick();
    end
    chk("wrap_count", got.size(), 14);
    for (int i = 0; i < got.size() && i < 14; i++)
      chk($sformatf("wrap_order%0d", i), got[i], 32'(8 * i));
    chk("wrap_overflow", overflow, 0);
    chk("wrap_min_free_ge6", min_free >= 6, 1);
    chk("wrap_empty", empty, 1);

    // full and overflow
    do_reset();
    for (int k = 0; k < 4; k++) begin
      st_valid = 2'b11;
      st_addr[0] = 32'h300 + 32'(16 * k);
      st_addr[1] = 32'h308 + 32'(16 * k);
      tick();
    end
    st_valid = 2'b01;
    st_addr[0] = 32'h900;
    tick();
    st_valid = '0;
    #1;
    chk("full_free", free_slots, 0);
    chk("full_overflow", overflow, 1);
    got.delete();
    bus.mem2proc_response = 4'd2;
    for (int c = 0; c < 30; c++) begin
      record_issue();
      tick();
    end
    chk("full_drained", got.size(), 8);
    n = 0;
    foreach (got[i]) if (got[i] == 32'h900) n++;
    chk("full_ninth_absent", n, 0);
    chk("full_overflow_sticky", overflow, 1);

    // conflict probing
    do_reset();
    st_valid[0] = 1'b1;
    st_addr[0] = 32'h200;
    ld_check_addr = 32'h200;
    #1;
    chk("cf_enq_excluded", ld_conflict, 0);
    st_addr[0] = 32'h204;
    tick();
    st_valid = '0;
    ld_check_addr = 32'h200;
    #1;
    chk("cf_hit_200", ld_conflict, 1);
    ld_check_addr = 32'h208;
    #1;
    chk("cf_miss_208", ld_conflict, 0);
    bus.mem2proc_response = 4'd1;
    for (int c = 0; c < 10 && !empty; c++) tick();
    chk("cf_drained", empty, 1);
    ld_check_addr = 32'h200;
    #1;
    chk("cf_after_drain", ld_conflict, 0);

    // reset in the middle of a request
    do_reset();
    st_valid = 2'b11;
    st_addr[0] = 32'h10;
    st_addr[1] = 32'h18;
    tick();
    st_valid = 2'b01;
    st_addr[0] = 32'h20;
    tick();
    st_valid = '0;
    for (int c = 0; c < 5 && bus.proc2mem_command != 2; c++) tick();
    chk("mid_in_req", bus.proc2mem_command, 2);
    reset = 1'b1;
    bus.mem2proc_response = 4'd1;
    tick();
    reset = 1'b0;
    chk("mid_cmd", bus.proc2mem_command, 0);
    chk("mid_free", free_slots, D);
    chk("mid_empty", empty, 1);
    tick();
    chk("mid_cmd_next", bus.proc2mem_command, 0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      room = D - mq.size();
      st_valid = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0 &&
            (room > 0 || $urandom_range(0, 31) == 0)) begin
          st_valid[i] = 1'b1;
          room--;
        end
        st_addr[i] = 32'($urandom_range(0, 15) << 3) |
                     32'($urandom_range(0, 7));
        st_data[i] = {$urandom, $urandom};
        st_size[i] = 2'($urandom_range(0, 3));
      end
      ld_check_addr = 32'($urandom_range(0, 15) << 3) |
                      32'($urandom_range(0, 7));
      bus.mem2proc_response = ($urandom_range(0, 9) < 4) ?
                              4'd0 : 4'($urandom_range(1, 15));
      reset = ($urandom_range(0, 299) == 0);
      #1;
      check_model();
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
